channel_scheduler: RTL

Sequences the transmitter's registered channel muxer. It drives the muxer's 4-bit channel select and walks a frame: one SYNC slot on channel 0, where the muxer emits its 0xEE default byte, then each enabled data channel in ascending order. It holds a valid/ready handshake toward the downstream serializer so each muxed byte is consumed exactly once. It sits between the transmitter top-level control and the input muxer/serializer pair.

---
 rtl/chsched_pkg.sv | 21 ++
 rtl/ch_next_sel.sv | 33 +++
 rtl/channel_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/chsched_pkg.sv
// Shared types and constants for the transmitter channel scheduler.
// Latency: none (declarations only).
// Backpressure: n/a.
package chsched_pkg;

  // Width of the muxer channel-select bus.
  localparam int CH_W = 4;

  // Channel code whose muxer output is the fixed sync byte.
  localparam logic [CH_W-1:0] SYNC_CH = 4'h0;

  // Byte the muxer presents on SYNC_CH.
  localparam logic [7:0] SYNC_BYTE = 8'hEE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    VALID  = 2'd2
  } state_t;

endpackage

// File: rtl/ch_next_sel.sv
// Finds the lowest enabled data channel strictly above the current channel.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   mask    - enabled data channels, bit i enables channel i+1
//   cur     - channel currently being served
//   next_ch - lowest enabled channel above cur (equals cur when none)
//   last    - no enabled channel remains above cur (frame end)
module ch_next_sel
  import chsched_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  output logic [CH_W-1:0]   next_ch,
  output logic              last
);

  // Walk from the top channel downwards so the last hit is the lowest one.
  always_comb begin
    next_ch = cur;
    last    = 1'b1;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (mask[i-1] && (CH_W'(i) > cur)) begin
        next_ch = CH_W'(i);
        last    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/channel_scheduler.sv
// Walks the muxer channel select through a frame (SYNC slot, then enabled channels ascending).
// Latency: MUX_LAT settle cycles per slot before data_valid, then one cycle after tx_ready to advance.
// Backpressure: data_valid and channel are held until tx_ready is sampled high (no byte dropped or repeated).
//
// Optional feature macro CHSCHED_TIMEOUT_EN: when defined, a slot left waiting
// TIMEOUT_CYCLES valid cycles without tx_ready is aborted, timeout_err pulses for
// one cycle and the frame advances. When undefined, timeout_err is constant 0.
//
// Ports:
//   clk         - system clock, rising edge
//   arst        - asynchronous active-low reset
//   enable      - run frames while high (sampled at frame boundaries)
//   ch_mask     - bit i enables data channel i+1 (latched at frame boundaries)
//   tx_ready    - serializer accepted the current byte
//   channel     - channel select to the muxer
//   data_valid  - muxer output byte is valid for the current slot
//   frame_start - high together with data_valid during the SYNC slot
//   busy        - high whenever the scheduler is not idle
//   timeout_err - one-cycle pulse on slot abort
module channel_scheduler #(
  parameter int                            NUM_CH         = 3,
  parameter logic [chsched_pkg::CH_W-1:0]  SYNC_CH        = chsched_pkg::SYNC_CH,
  parameter int                            MUX_LAT        = 1,
  parameter int                            TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          enable,
  input  logic [NUM_CH-1:0]             ch_mask,
  input  logic                          tx_ready,
  output logic [chsched_pkg::CH_W-1:0]  channel,
  output logic                          data_valid,
  output logic                          frame_start,
  output logic                          busy,
  output logic                          timeout_err
);

  import chsched_pkg::*;

  // Settle counter sized to hold MUX_LAT-1 (at least one bit).
  localparam int SC_W = (MUX_LAT > 1) ? $clog2(MUX_LAT) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(MUX_LAT - 1);

  state_t            state;
  logic [NUM_CH-1:0] shadow;
  logic [SC_W-1:0]   settle_cnt;
  logic [CH_W-1:0]   next_ch;
  logic              last_ch;
  logic              to_hit;
  logic              advance;
  logic              restart;

  ch_next_sel #(
    .NUM_CH (NUM_CH)
  ) u_next_sel (
    .mask    (shadow),
    .cur     (channel),
    .next_ch (next_ch),
    .last    (last_ch)
  );

`ifdef CHSCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  // Counts valid cycles of the current slot; any slot exit clears it so every
  // new slot starts from zero.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      to_cnt <= '0;
    end else if ((state != VALID) || advance) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (state == VALID) && !tx_ready && (to_cnt == TO_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  // A timeout abort moves the slot on exactly like an accepted byte.
  assign advance = tx_ready || to_hit;
  assign restart = enable && (|ch_mask);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state       <= IDLE;
      channel     <= SYNC_CH;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      shadow      <= '0;
      settle_cnt  <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (restart) begin
            shadow     <= ch_mask;
            channel    <= SYNC_CH;
            settle_cnt <= '0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end

        SETTLE: begin
          if (settle_cnt == SC_LAST) begin
            settle_cnt  <= '0;
            data_valid  <= 1'b1;
            frame_start <= (channel == SYNC_CH);
            state       <= VALID;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        VALID: begin
          if (advance) begin
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            timeout_err <= to_hit;
            settle_cnt  <= '0;
            if (!last_ch) begin
              channel <= next_ch;
              state   <= SETTLE;
            end else if (restart) begin
              // Frame boundary: the new mask only takes effect here.
              shadow  <= ch_mask;
              channel <= SYNC_CH;
              state   <= SETTLE;
            end else begin
              // Channel keeps its last value while idle.
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        default: begin
          data_valid  <= 1'b0;
          frame_start <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
